prng_checker: RTL and testbench

Receive-side companion to the `rand` pseudo-random generator: consumes the 32-bit word stream produced by a generator and checks that it follows the same LFSR sequence. It self-synchronises to the incoming stream, declares lock after a programmable run of correct words, then counts word errors and drops lock after a programmable run of consecutive misses. It sits on the bus-side or loopback path as a BIST/link-integrity monitor.

---
 rtl/prng_checker.sv | 130 +++++++++++++
 tb/tb_prng_checker.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/prng_checker.sv
// prng_checker: self-synchronising checker for a 32-bit LFSR word stream
// (x^32+x^22+x^2+x+1). Seeds from the first nonzero word, locks after
// LOCK_CNT correct predictions, counts mismatches while locked and drops
// lock after LOSS_CNT consecutive misses.
module prng_checker #(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             valid_i,
  input  logic [31:0]      number_i,
  output logic             locked_o,
  output logic             error_o,
  output logic [CNT_W-1:0] err_count_o,
  output logic [31:0]      expected_o
);

  // Counters only need to hold LOCK_CNT-1 / LOSS_CNT-1; keep at least one bit.
  localparam int MW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
  localparam int LW = (LOSS_CNT > 1) ? $clog2(LOSS_CNT) : 1;
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);
  localparam logic [LW-1:0] MISS_LAST  = LW'(LOSS_CNT - 1);

  typedef enum logic [1:0] {IDLE, SYNC, LOCKED} state_t;

  state_t             state_reg, state_next;
  logic [31:0]        exp_reg, exp_next;
  logic [MW-1:0]      match_cnt_reg, match_cnt_next;
  logic [LW-1:0]      miss_cnt_reg, miss_cnt_next;
  logic [CNT_W-1:0]   err_cnt_reg, err_cnt_next;
  logic               error_reg, error_next;
  logic               locked_reg;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  // State and datapath registers; locked_o is a registered decode of the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      exp_reg       <= 32'h0;
      match_cnt_reg <= '0;
      miss_cnt_reg  <= '0;
      err_cnt_reg   <= '0;
      error_reg     <= 1'b0;
      locked_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      exp_reg       <= exp_next;
      match_cnt_reg <= match_cnt_next;
      miss_cnt_reg  <= miss_cnt_next;
      err_cnt_reg   <= err_cnt_next;
      error_reg     <= error_next;
      locked_reg    <= (state_next == LOCKED);
    end
  end

  // Next-state and datapath update; clear overrides any word presented with it.
  always_comb begin
    state_next     = state_reg;
    exp_next       = exp_reg;
    match_cnt_next = match_cnt_reg;
    miss_cnt_next  = miss_cnt_reg;
    err_cnt_next   = err_cnt_reg;
    error_next     = 1'b0;
    if (clear_i) begin
      state_next     = IDLE;
      match_cnt_next = '0;
      miss_cnt_next  = '0;
      err_cnt_next   = '0;
    end else if (valid_i) begin
      case (state_reg)
        IDLE: begin
          if (number_i != 32'h0) begin
            exp_next       = lfsr_next(number_i);
            match_cnt_next = '0;
            state_next     = SYNC;
          end
        end
        SYNC: begin
          if (number_i == exp_reg) begin
            exp_next       = lfsr_next(exp_reg);
            match_cnt_next = match_cnt_reg + 1'b1;
            if (match_cnt_reg == MATCH_LAST) begin
              match_cnt_next = '0;
              miss_cnt_next  = '0;
              state_next     = LOCKED;
            end
          end else if (number_i != 32'h0) begin
            // Treat the unexpected word as a fresh seed.
            exp_next       = lfsr_next(number_i);
            match_cnt_next = '0;
          end else begin
            match_cnt_next = '0;
            state_next     = IDLE;
          end
        end
        LOCKED: begin
          // Free-run on our own prediction so a bad word cannot poison later ones.
          exp_next = lfsr_next(exp_reg);
          if (number_i == exp_reg) begin
            miss_cnt_next = '0;
          end else begin
            error_next = 1'b1;
            if (err_cnt_reg != {CNT_W{1'b1}}) begin
              err_cnt_next = err_cnt_reg + 1'b1;
            end
            if (miss_cnt_reg == MISS_LAST) begin
              miss_cnt_next = '0;
              state_next    = IDLE;
            end else begin
              miss_cnt_next = miss_cnt_reg + 1'b1;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign locked_o    = locked_reg;
  assign error_o     = error_reg;
  assign err_count_o = err_cnt_reg;
  assign expected_o  = exp_reg;

endmodule

// File: tb/tb_prng_checker.sv
// Directed bench for prng_checker: table of per-cycle vectors for lock,
// corruption, loss and relock, then hand-written multi-cycle sequences.
// A second instance with CNT_W=2 shares the stimulus to exercise saturation.
module tb_prng_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear_i;
  logic        valid_i;
  logic [31:0] number_i;
  logic        locked_o, error_o;
  logic [15:0] err_count_o;
  logic [31:0] expected_o;
  logic        locked2, error2;
  logic [1:0]  err_count2;
  logic [31:0] expected2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  prng_checker dut (
    .clk(clk), .reset(reset), .clear_i(clear_i), .valid_i(valid_i),
    .number_i(number_i), .locked_o(locked_o), .error_o(error_o),
    .err_count_o(err_count_o), .expected_o(expected_o)
  );

  prng_checker #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .clear_i(clear_i), .valid_i(valid_i),
    .number_i(number_i), .locked_o(locked2), .error_o(error2),
    .err_count_o(err_count2), .expected_o(expected2)
  );

  typedef struct {
    logic        valid;
    logic        clear;
    logic [31:0] number;
    logic        locked;
    logic        err;
    logic [15:0] cnt;
    logic [31:0] expv;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] nx(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  function automatic void push(input logic v, input logic c, input logic [31:0] n,
                               input logic lk, input logic er, input logic [15:0] cn,
                               input logic [31:0] ex);
    vec_t r;
    r.valid = v; r.clear = c; r.number = n;
    r.locked = lk; r.err = er; r.cnt = cn; r.expv = ex;
    tbl.push_back(r);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Drive one cycle of inputs shortly after a rising edge, return 1 after the next one.
  task automatic step(input logic v, input logic c, input logic [31:0] n);
    valid_i = v; clear_i = c; number_i = n;
    @(posedge clk); #1;
    $display("t=%0t valid=%0b clear=%0b word=%08h -> locked=%0b error=%0b count=%0d expected=%08h",
             $time, v, c, n, locked_o, error_o, err_count_o, expected_o);
  endtask

  logic [31:0] s, t, g, a, b, r;
  logic [15:0] sat;

  initial begin
    reset = 1'b0; clear_i = 1'b0; valid_i = 1'b0; number_i = 32'h0;

    // Reset values before any clock edge.
    #2;
    chk("reset locked", 32'(locked_o), 32'h0);
    chk("reset error", 32'(error_o), 32'h0);
    chk("reset count", 32'(err_count_o), 32'h0);
    chk("reset expected", expected_o, 32'h0);

    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // Clean stream from seed 1: 1,3,6,D,1B,36,6D; lock after 0x1B is sampled.
    chk("model 0x36", nx(nx(nx(nx(32'h1)))) == 32'h1B ? nx(32'h1B) : 32'h0, 32'h36);
    s = 32'h1;
    for (int k = 0; k < 7; k++) begin
      push(1'b1, 1'b0, s, (k >= 4), 1'b0, 16'd0, nx(s));
      s = nx(s);
    end
    push(1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 16'd0, s);     // gap: nothing moves
    push(1'b1, 1'b0, s ^ 32'h1, 1'b1, 1'b1, 16'd1, nx(s));     // single corruption
    s = nx(s);
    push(1'b1, 1'b0, s, 1'b1, 1'b0, 16'd1, nx(s));             // next word matches
    s = nx(s);
    for (int i = 0; i < 3; i++) begin                          // loss of lock
      push(1'b1, 1'b0, ~s, (i < 2), 1'b1, 16'(2 + i), nx(s));
      s = nx(s);
    end
    t = 32'h1234_5678;                                         // relock on new seed
    for (int k = 0; k < 6; k++) begin
      push(1'b1, 1'b0, t, (k >= 4), 1'b0, 16'd4, nx(t));
      t = nx(t);
    end

    foreach (tbl[i]) begin
      step(tbl[i].valid, tbl[i].clear, tbl[i].number);
      sat = (tbl[i].cnt > 16'd3) ? 16'd3 : tbl[i].cnt;
      chk($sformatf("row%0d locked", i), 32'(locked_o), 32'(tbl[i].locked));
      chk($sformatf("row%0d error", i), 32'(error_o), 32'(tbl[i].err));
      chk($sformatf("row%0d count", i), 32'(err_count_o), 32'(tbl[i].cnt));
      chk($sformatf("row%0d sat count", i), 32'(err_count2), 32'(sat));
      chk($sformatf("row%0d expected", i), expected_o, tbl[i].expv);
    end
    g = t;

    // Fifth error: wide counter reaches 5, 2-bit counter stays saturated at 3.
    step(1'b1, 1'b0, ~g); g = nx(g);
    chk("fifth err error", 32'(error_o), 32'h1);
    chk("fifth err count", 32'(err_count_o), 32'd5);
    chk("fifth err sat", 32'(err_count2), 32'd3);
    chk("fifth err locked", 32'(locked_o), 32'h1);

    // Random gaps between correct words leave lock and count untouched.
    for (int i = 0; i < 8; i++) begin
      int gaps;
      gaps = $urandom_range(0, 2);
      for (int j = 0; j < gaps; j++) begin
        step(1'b0, 1'b0, $urandom);
        chk("gap error", 32'(error_o), 32'h0);
        chk("gap expected", expected_o, g);
      end
      step(1'b1, 1'b0, g);
      chk("gap word locked", 32'(locked_o), 32'h1);
      chk("gap word count", 32'(err_count_o), 32'd5);
      chk("gap word expected", expected_o, nx(g));
      g = nx(g);
    end

    // Clear with a (wrong) valid word: word discarded, IDLE, counts zeroed.
    step(1'b1, 1'b1, ~g);
    chk("clear locked", 32'(locked_o), 32'h0);
    chk("clear error", 32'(error_o), 32'h0);
    chk("clear count", 32'(err_count_o), 32'h0);
    chk("clear sat count", 32'(err_count2), 32'h0);

    // Zero in IDLE is ignored; zero in SYNC returns to IDLE, so the next word reseeds.
    step(1'b1, 1'b0, 32'h0);
    chk("idle zero locked", 32'(locked_o), 32'h0);
    a = 32'hA5A5_0001;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, a);
      chk("sync pre-zero expected", expected_o, nx(a));
      a = nx(a);
    end
    step(1'b1, 1'b0, 32'h0);
    chk("sync zero locked", 32'(locked_o), 32'h0);
    chk("sync zero error", 32'(error_o), 32'h0);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, a);
      chk($sformatf("reseed-after-zero locked k%0d", k), 32'(locked_o), 32'(k == 4));
      a = nx(a);
    end
    chk("reseed-after-zero expected", expected_o, a);

    // SYNC reseed on a wrong nonzero word restarts the match count, no error.
    step(1'b1, 1'b1, 32'h0);
    b = 32'h0000_BEEF;
    step(1'b1, 1'b0, b); b = nx(b);
    step(1'b1, 1'b0, b); b = nx(b);
    r = 32'h0F0F_0F0F;
    step(1'b1, 1'b0, r);
    chk("reseed expected", expected_o, nx(r));
    chk("reseed error", 32'(error_o), 32'h0);
    chk("reseed count", 32'(err_count_o), 32'h0);
    r = nx(r);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, r);
      chk($sformatf("reseed lock k%0d", k), 32'(locked_o), 32'(k == 3));
      r = nx(r);
    end

    // Mismatch while locked, then async reset between edges.
    step(1'b1, 1'b0, ~r);
    chk("pre-reset error", 32'(error_o), 32'h1);
    chk("pre-reset count", 32'(err_count_o), 32'h1);
    valid_i = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("async locked", 32'(locked_o), 32'h0);
    chk("async error", 32'(error_o), 32'h0);
    chk("async count", 32'(err_count_o), 32'h0);
    chk("async expected", expected_o, 32'h0);
    chk("async sat count", 32'(err_count2), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
